uart_tick_gen: RTL and testbench
================================

Name: uart_tick_gen

Overview:
Parametrised timing generator for the UART datapath. It produces three things from the system clock. An oversample tick at a runtime-programmable divisor. A bit tick and a mid-bit sample tick every OVS oversample ticks. A wrapping PHASE_W-bit phase counter that advances on each bit tick. TX and RX shift logic consume these ticks, and sync lets RX realign the bit timing to a start-bit edge.

Parameters:
DIV_W, 16, width of divisor register and prescaler counter
DIV_RST, 10000, divisor value loaded at reset
OVS, 16, oversample ticks per bit; integer >= 2
PHASE_W, 2, width of phase counter output

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  count enable; when low all counters hold and no ticks are produced
sync  input  1  synchronous restart of prescaler and oversample counter
div_load  input  1  capture div_in into pending divisor
div_in  input  DIV_W  new divisor value
os_tick  output  1  one-cycle oversample tick
mid_tick  output  1  one-cycle pulse at mid-bit (oversample count OVS/2)
bit_tick  output  1  one-cycle pulse at bit boundary
phase  output  PHASE_W  bit phase counter
wrap  output  1  one-cycle pulse when phase wraps to 0
div_cur  output  DIV_W  divisor currently in effect

Behaviour:
- Reset (reset low, async): prescaler=0, os_cnt=0, phase=0, div_cur=DIV_RST, pending-valid=0, all tick outputs=0.
- Effective divisor div_eff = max(div_cur,1). A value of 0 behaves as 1, which gives os_tick every enabled cycle.
- Prescaler, on each rising edge with en=1 and sync=0:
  - if prescaler==div_eff-1: prescaler<=0, os_tick<=1.
  - else: prescaler<=prescaler+1, os_tick<=0.
- All tick outputs are registered and high for exactly one cycle. First os_tick is high in the cycle after the div_eff-th enabled edge following reset.
- Oversample counter os_cnt (0..OVS-1) changes only on an edge that sets os_tick:
  - if os_cnt==OVS-1: os_cnt<=0, bit_tick<=1.
  - else: os_cnt<=os_cnt+1.
  - mid_tick<=1 on the edge where os_cnt transitions to OVS/2 (integer division).
- Phase: on the edge asserting bit_tick, phase<=phase+1 modulo 2^PHASE_W. wrap<=1 on the same edge when phase goes from all-ones to 0.
- en=0: prescaler, os_cnt and phase hold. Tick outputs go 0 on the next edge. A pending divisor load is applied on that next edge.
- sync=1 (takes precedence over en):
  - prescaler<=0, os_cnt<=0, all ticks<=0.
  - phase and div_cur unchanged.
  - sync on a would-be tick edge suppresses that tick.
- Divisor load: div_load=1 captures div_in into pending and sets pending-valid. A second load before application overwrites pending (last wins).
- Divisor application: pending is applied (div_cur<=pending, valid<=0) on the first edge where any of these holds:
  - os_tick is being set, so the new divisor starts with the next period;
  - en=0;
  - sync=1.
- The current period always completes with the old divisor. div_load and application on the same edge: the new div_in is captured, and the value applied is the previously pending one.
- No combinational path from inputs to outputs.

Test Plan:
1. DIV_RST=4, OVS=4, PHASE_W=2, en=1 from reset release. Required response:
   - os_tick high after edges 4, 8, 12, 16;
   - mid_tick with the 2nd os_tick (edge 8);
   - bit_tick with the 4th os_tick (edge 16), phase 0->1;
   - wrap with the 16th os_tick (edge 64), phase 3->0.
2. Divisor change mid-period: at edge 2, load div_in=6. Required response: os_tick at edge 4 (old divisor), then edges 10 and 16; div_cur reads 6 from edge 4.
3. div_in=0 loaded and applied. Required response: os_tick every enabled cycle; bit_tick every OVS cycles.
4. en dropped for 5 cycles mid-period at prescaler=2. Required response: counters hold, no ticks; after en re-asserts, os_tick follows 2 edges later (period resumes from prescaler=2).
5. sync asserted on the edge where os_tick would fire. Required response: no tick; prescaler and os_cnt = 0; phase unchanged; next os_tick div_eff edges after sync release.
6. reset asserted asynchronously between edges mid-count. Required response: all outputs 0 and div_cur=DIV_RST immediately, without waiting for a clock edge; pending load discarded.

Source files
------------

// File: rtl/uart_tick_gen.sv
// ---------------------------------------------------------------------------
// uart_tick_gen
//
// Timing generator for the UART datapath. A prescaler divides the system
// clock by a runtime-programmable divisor to make the oversample tick. Every
// OVS oversample ticks it emits a bit tick, and halfway through each bit it
// emits a mid-bit sample tick. A small phase counter advances on every bit
// tick and flags its wrap back to zero. RX can pulse sync to realign the bit
// timing to a start-bit edge.
//
// Parameters
//   DIV_W    width of the divisor register and the prescaler counter
//   DIV_RST  divisor in effect after reset
//   OVS      oversample ticks per bit (>= 2)
//   PHASE_W  width of the phase counter
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   en        count enable; when low all counters hold and no ticks occur
//   sync      synchronous restart of prescaler and oversample counter
//   div_load  capture div_in into the pending divisor
//   div_in    new divisor value
//   os_tick   one-cycle oversample tick
//   mid_tick  one-cycle pulse when the oversample count reaches OVS/2
//   bit_tick  one-cycle pulse at the bit boundary
//   phase     bit phase counter
//   wrap      one-cycle pulse when phase wraps to 0
//   div_cur   divisor currently in effect
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// ---------------------------------------------------------------------------
module uart_tick_gen #(
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 10000,
  parameter int OVS     = 16,
  parameter int PHASE_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sync,
  input  logic               div_load,
  input  logic [DIV_W-1:0]   div_in,
  output logic               os_tick,
  output logic               mid_tick,
  output logic               bit_tick,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap,
  output logic [DIV_W-1:0]   div_cur
);

  // Oversample counter width; at least one bit even for the smallest OVS.
  localparam int OSC_W = (OVS > 2) ? $clog2(OVS) : 1;

  localparam logic [OSC_W-1:0] OS_LAST = OSC_W'(OVS - 1);
  localparam logic [OSC_W-1:0] OS_MID  = OSC_W'(OVS / 2);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0]   presc_reg,      presc_next;
  logic [OSC_W-1:0]   os_cnt_reg,     os_cnt_next;
  logic [PHASE_W-1:0] phase_reg,      phase_next;
  logic [DIV_W-1:0]   div_cur_reg,    div_cur_next;
  logic [DIV_W-1:0]   div_pend_reg,   div_pend_next;
  logic               pend_valid_reg, pend_valid_next;
  logic               os_tick_reg,    os_tick_next;
  logic               mid_tick_reg,   mid_tick_next;
  logic               bit_tick_reg,   bit_tick_next;
  logic               wrap_reg,       wrap_next;

  logic [DIV_W-1:0]   div_eff;
  logic               os_fire;
  logic               div_apply;

  // A programmed divisor of 0 is treated as 1 so the prescaler never stalls.
  always_comb begin
    div_eff = (div_cur_reg == '0) ? DIV_ONE : div_cur_reg;
  end

  // The edge that ends the current prescaler period. sync wins over en and
  // suppresses the tick that would otherwise have fired here.
  always_comb begin
    os_fire = en && !sync && (presc_reg == (div_eff - DIV_ONE));
  end

  // -------------------------------------------------------------------------
  // Prescaler, oversample counter and phase
  // -------------------------------------------------------------------------
  always_comb begin
    presc_next    = presc_reg;
    os_cnt_next   = os_cnt_reg;
    phase_next    = phase_reg;
    os_tick_next  = 1'b0;
    mid_tick_next = 1'b0;
    bit_tick_next = 1'b0;
    wrap_next     = 1'b0;

    if (sync) begin
      // Realign: restart the bit from its first oversample slot. phase is
      // left alone so the consumer keeps its notion of which bit it is on.
      presc_next  = '0;
      os_cnt_next = '0;
    end else if (en) begin
      if (os_fire) begin
        presc_next   = '0;
        os_tick_next = 1'b1;
        if (os_cnt_reg == OS_LAST) begin
          os_cnt_next   = '0;
          bit_tick_next = 1'b1;
          phase_next    = phase_reg + PHASE_W'(1);
          wrap_next     = (phase_reg == {PHASE_W{1'b1}});
        end else begin
          os_cnt_next = os_cnt_reg + OSC_W'(1);
        end
        // Mid-bit sample point: the oversample count is just arriving at
        // OVS/2 on this tick.
        mid_tick_next = (os_cnt_next == OS_MID);
      end else begin
        presc_next = presc_reg + DIV_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Divisor staging
  //
  // A new divisor waits in the pending register until a safe point: the end
  // of the current prescaler period (so that period finishes on the old
  // divisor), an idle cycle, or a sync restart. A load on the same edge as an
  // application lands in the pending register and stays valid; the value
  // applied on that edge is the one that was already pending.
  // -------------------------------------------------------------------------
  always_comb begin
    div_apply = pend_valid_reg && (os_fire || !en || sync);
  end

  always_comb begin
    div_cur_next    = div_cur_reg;
    div_pend_next   = div_pend_reg;
    pend_valid_next = pend_valid_reg;

    if (div_apply) begin
      div_cur_next    = div_pend_reg;
      pend_valid_next = 1'b0;
    end

    if (div_load) begin
      div_pend_next   = div_in;
      pend_valid_next = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg      <= '0;
      os_cnt_reg     <= '0;
      phase_reg      <= '0;
      div_cur_reg    <= DIV_INIT;
      div_pend_reg   <= '0;
      pend_valid_reg <= 1'b0;
      os_tick_reg    <= 1'b0;
      mid_tick_reg   <= 1'b0;
      bit_tick_reg   <= 1'b0;
      wrap_reg       <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      os_cnt_reg     <= os_cnt_next;
      phase_reg      <= phase_next;
      div_cur_reg    <= div_cur_next;
      div_pend_reg   <= div_pend_next;
      pend_valid_reg <= pend_valid_next;
      os_tick_reg    <= os_tick_next;
      mid_tick_reg   <= mid_tick_next;
      bit_tick_reg   <= bit_tick_next;
      wrap_reg       <= wrap_next;
    end
  end

  assign os_tick  = os_tick_reg;
  assign mid_tick = mid_tick_reg;
  assign bit_tick = bit_tick_reg;
  assign phase    = phase_reg;
  assign wrap     = wrap_reg;
  assign div_cur  = div_cur_reg;

endmodule

// File: tb/tb_uart_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_uart_tick_gen
//
// Self-checking bench for uart_tick_gen with a small configuration
// (DIV_RST=4, OVS=4, PHASE_W=2). A reference model counts enabled edges in
// the current period, oversample ticks in the current bit and total bits,
// and derives the expected outputs from those counts every cycle. Directed
// scenarios add fixed-edge checks on top of the model.
// ---------------------------------------------------------------------------
module tb_uart_tick_gen;

  localparam int DIV_W   = 16;
  localparam int DIV_RST = 4;
  localparam int OVS     = 4;
  localparam int PHASE_W = 2;
  localparam int NPH     = 1 << PHASE_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               sync;
  logic               div_load;
  logic [DIV_W-1:0]   div_in;
  logic               os_tick;
  logic               mid_tick;
  logic               bit_tick;
  logic [PHASE_W-1:0] phase;
  logic               wrap;
  logic [DIV_W-1:0]   div_cur;

  always #5 clk = ~clk;

  uart_tick_gen #(
    .DIV_W  (DIV_W),
    .DIV_RST(DIV_RST),
    .OVS    (OVS),
    .PHASE_W(PHASE_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .div_load(div_load),
    .div_in  (div_in),
    .os_tick (os_tick),
    .mid_tick(mid_tick),
    .bit_tick(bit_tick),
    .phase   (phase),
    .wrap    (wrap),
    .div_cur (div_cur)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model state
  int m_pos;     // enabled edges consumed in the current prescaler period
  int m_osn;     // oversample ticks seen in the current bit
  int m_bits;    // total bit ticks since reset
  int m_div;     // divisor in effect
  int m_pend;    // pending divisor
  bit m_pend_v;
  bit e_os, e_mid, e_bit, e_wrap;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_osn = 0; m_bits = 0;
    m_div = DIV_RST; m_pend = 0; m_pend_v = 0;
    e_os = 0; e_mid = 0; e_bit = 0; e_wrap = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_step();
    int eff;
    bit apply;
    eff = (m_div == 0) ? 1 : m_div;
    e_os = 0; e_mid = 0; e_bit = 0; e_wrap = 0;
    if (sync) begin
      m_pos = 0;
      m_osn = 0;
    end else if (en) begin
      if (m_pos + 1 == eff) begin
        m_pos = 0;
        e_os = 1;
        m_osn++;
        if (m_osn == OVS / 2) e_mid = 1;
        if (m_osn == OVS) begin
          m_osn = 0;
          e_bit = 1;
          m_bits++;
          e_wrap = (m_bits % NPH == 0);
        end
      end else begin
        m_pos = (m_pos + 1) % (1 << DIV_W);
      end
    end
    apply = m_pend_v && (e_os || !en || sync);
    if (apply) begin
      m_div = m_pend;
      m_pend_v = 0;
    end
    if (div_load) begin
      m_pend = int'(div_in);
      m_pend_v = 1;
    end
  endtask

  task automatic check_outputs();
    check_val("os_tick", os_tick, e_os);
    check_val("mid_tick", mid_tick, e_mid);
    check_val("bit_tick", bit_tick, e_bit);
    check_val("phase", phase, m_bits % NPH);
    check_val("wrap", wrap, e_wrap);
    check_val("div_cur", div_cur, m_div);
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_step();
    #1;
    check_outputs();
  endtask

  // Assert reset between clock edges, confirm the outputs clear at once,
  // then release it on a falling edge with en=1.
  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_val("rst_os_tick", os_tick, 0);
    check_val("rst_mid_tick", mid_tick, 0);
    check_val("rst_bit_tick", bit_tick, 0);
    check_val("rst_phase", phase, 0);
    check_val("rst_wrap", wrap, 0);
    check_val("rst_div_cur", div_cur, DIV_RST);
    model_reset();
    div_load = 1'b0;
    sync = 1'b0;
    en = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    int cnt_os, cnt_bit, wait_n, saved_ph;
    bit found;

    reset = 1'b0; en = 1'b0; sync = 1'b0; div_load = 1'b0; div_in = '0;
    model_reset();
    #12;
    check_val("init_os_tick", os_tick, 0);
    check_val("init_phase", phase, 0);
    check_val("init_div_cur", div_cur, DIV_RST);

    // 1: basic tick cadence from reset
    do_reset();
    for (int i = 0; i < 64; i++) begin
      step();
      if (edge_n == 4)  check_val("t1_os_e4", os_tick, 1);
      if (edge_n == 8)  check_val("t1_mid_e8", mid_tick, 1);
      if (edge_n == 16) begin
        check_val("t1_bit_e16", bit_tick, 1);
        check_val("t1_phase_e16", phase, 1);
      end
      if (edge_n == 64) begin
        check_val("t1_wrap_e64", wrap, 1);
        check_val("t1_phase_e64", phase, 0);
      end
    end
    $display("t1 cadence done at edge %0d", edge_n);

    // 2: divisor change mid-period
    do_reset();
    step();
    div_load = 1'b1; div_in = 16'd6;
    step();
    div_load = 1'b0;
    while (edge_n < 16) begin
      step();
      if (edge_n == 3)  check_val("t2_div_e3", div_cur, 4);
      if (edge_n == 4) begin
        check_val("t2_os_e4", os_tick, 1);
        check_val("t2_div_e4", div_cur, 6);
      end
      if (edge_n == 10) check_val("t2_os_e10", os_tick, 1);
      if (edge_n == 16) check_val("t2_os_e16", os_tick, 1);
    end
    $display("t2 divisor change done, div_cur=%0d", div_cur);

    // 3: divisor 0 behaves as 1
    div_load = 1'b1; div_in = '0;
    step();
    div_load = 1'b0;
    wait_n = 0;
    while ((m_div != 0 || m_pend_v) && wait_n < 40) begin
      step();
      wait_n++;
    end
    check_val("t3_div0_applied", div_cur, 0);
    cnt_os = 0; cnt_bit = 0;
    for (int i = 0; i < 2 * OVS; i++) begin
      step();
      cnt_os += int'(os_tick);
      cnt_bit += int'(bit_tick);
    end
    check_val("t3_os_count", cnt_os, 2 * OVS);
    check_val("t3_bit_count", cnt_bit, 2);
    $display("t3 div0: %0d os ticks, %0d bit ticks", cnt_os, cnt_bit);

    // 4: en low for 5 cycles with prescaler at 2
    do_reset();
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("t4_hold_os", os_tick, 0);
    end
    en = 1'b1;
    step();
    check_val("t4_resume_e1", os_tick, 0);
    step();
    check_val("t4_resume_e2", os_tick, 1);
    $display("t4 enable gap done at edge %0d", edge_n);

    // 5: sync on the would-be tick edge
    wait_n = 0;
    while (m_pos != DIV_RST - 1 && wait_n < 20) begin
      step();
      wait_n++;
    end
    check_val("t5_reached_tick_edge", m_pos, DIV_RST - 1);
    saved_ph = m_bits % NPH;
    sync = 1'b1;
    step();
    sync = 1'b0;
    check_val("t5_suppressed", os_tick, 0);
    check_val("t5_phase_kept", phase, saved_ph);
    found = 0; wait_n = 0;
    while (!found && wait_n < 20) begin
      step();
      wait_n++;
      found = (os_tick == 1'b1);
    end
    check_val("t5_next_tick_found", found, 1);
    check_val("t5_next_tick_dist", wait_n, DIV_RST);
    $display("t5 sync: next os_tick %0d edges after release", wait_n);

    // 6: async reset mid-count discards a pending load
    step();
    div_load = 1'b1; div_in = 16'd9;
    step();
    div_load = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      if (edge_n == 4) check_val("t6_os_e4", os_tick, 1);
    end
    check_val("t6_div_kept", div_cur, DIV_RST);
    $display("t6 async reset done, div_cur=%0d", div_cur);

    // Randomised traffic against the model. en only drops while a divisor
    // is pending if the current period has not started, so an applied
    // smaller divisor never strands the prescaler above its terminal count.
    for (int i = 0; i < 3000; i++) begin
      sync = ($urandom_range(0, 19) == 0);
      div_load = ($urandom_range(0, 5) == 0);
      div_in = DIV_W'($urandom_range(0, 7));
      en = ($urandom_range(0, 7) != 0);
      if (m_pend_v && m_pos != 0) en = 1'b1;
      if (div_load && m_pos != 0) en = 1'b1;
      step();
    end
    sync = 1'b0; div_load = 1'b0; en = 1'b1;
    $display("random phase done at edge %0d", edge_n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
